// File: rtl/adc_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl_if
// Signal bundle between the ADC capture controller and its environment:
// pre-synchronized commands and trigger from the host side, the ADC sample
// input, the sample FIFO write port and the capture status flags.
//
// Modports
//   master : the capture controller (consumes commands/trigger/ADC data,
//            drives the FIFO write port and status)
//   slave  : the environment (host command logic, ADC register, FIFO)
//
// Parameters
//   DATA_W : ADC sample width
//   CNT_W  : sample counter width
//   OFS_W  : trigger offset counter width
// ---------------------------------------------------------------------------
interface adc_capture_ctrl_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned OFS_W  = 32
);

  logic              cmd_arm_i;
  logic              cmd_abort_i;
  logic              trigger_i;
  logic              trigger_mode_i;
  logic              trigger_wait_i;
  logic [CNT_W-1:0]  samples_i;
  logic [OFS_W-1:0]  offset_i;
  logic [DATA_W-1:0] adc_data_i;
  logic              fifo_full_i;
  logic              fifo_wr_en_o;
  logic [DATA_W-1:0] fifo_data_o;
  logic              armed_o;
  logic              capturing_o;
  logic              done_o;
  logic              overflow_o;

  modport master (
    input  cmd_arm_i,
    input  cmd_abort_i,
    input  trigger_i,
    input  trigger_mode_i,
    input  trigger_wait_i,
    input  samples_i,
    input  offset_i,
    input  adc_data_i,
    input  fifo_full_i,
    output fifo_wr_en_o,
    output fifo_data_o,
    output armed_o,
    output capturing_o,
    output done_o,
    output overflow_o
  );

  modport slave (
    output cmd_arm_i,
    output cmd_abort_i,
    output trigger_i,
    output trigger_mode_i,
    output trigger_wait_i,
    output samples_i,
    output offset_i,
    output adc_data_i,
    output fifo_full_i,
    input  fifo_wr_en_o,
    input  fifo_data_o,
    input  armed_o,
    input  capturing_o,
    input  done_o,
    input  overflow_o
  );

endinterface

// File: rtl/adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl
// Sequences a single ADC capture in the ADC sample-clock domain: arm,
// optional wait for the trigger to go inactive, trigger qualification, then
// exactly N sample writes into the sample FIFO followed by a one-cycle done
// pulse. A full FIFO truncates the capture and sets a sticky overflow flag;
// abort returns to idle at any time without a done pulse.
//
// Ports
//   clk    : ADC sample clock, all logic on the rising edge
//   reset  : asynchronous, active-high
//   bus    : adc_capture_ctrl_if.master
//            cmd_arm_i / cmd_abort_i   one-cycle command pulses (synchronized)
//            trigger_i, trigger_mode_i trigger and its active level
//            trigger_wait_i            require trigger inactive before arming
//            samples_i / offset_i      capture length / trigger delay, latched on arm
//            adc_data_i                ADC sample
//            fifo_full_i               sample FIFO full
//            fifo_wr_en_o/fifo_data_o  registered FIFO write port
//            armed_o / capturing_o     registered state flags
//            done_o                    one-cycle completion pulse
//            overflow_o                sticky FIFO-full-during-capture flag
//
// Build option
//   ADC_TRIG_OFFSET_EN : when defined, adds an OFFSET state that delays the
//   first sample by offset_i clocks after the trigger edge. When undefined,
//   offset_i is ignored and capture starts right after the trigger edge.
// ---------------------------------------------------------------------------
module adc_capture_ctrl #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned OFS_W  = 32
) (
  input logic                clk,
  input logic                reset,
  adc_capture_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_INACT,
    ST_ARMED,
    ST_OFFSET,
    ST_CAPTURE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  samples_q, samples_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              armed_q, armed_d;
  logic              cap_q, cap_d;
  logic              trig_active;

`ifdef ADC_TRIG_OFFSET_EN
  // Holds the latched offset, then counts it down while in OFFSET.
  logic [OFS_W-1:0]  ofs_q, ofs_d;
`else
  logic              unused_offset;
  assign unused_offset = ^bus.offset_i;
`endif

  assign trig_active = (bus.trigger_i == bus.trigger_mode_i);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    samples_d = samples_q;
    wr_en_d   = 1'b0;
    data_d    = data_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
`ifdef ADC_TRIG_OFFSET_EN
    ofs_d     = ofs_q;
`endif

    if (bus.cmd_abort_i) begin
      // Abort beats everything, including a simultaneous arm in IDLE.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_arm_i) begin
            samples_d = bus.samples_i;
`ifdef ADC_TRIG_OFFSET_EN
            ofs_d     = bus.offset_i;
`endif
            ovf_d     = 1'b0;
            state_d   = bus.trigger_wait_i ? ST_WAIT_INACT : ST_ARMED;
          end
        end

        ST_WAIT_INACT: begin
          if (!trig_active) begin
            state_d = ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (trig_active) begin
            count_d = '0;
`ifdef ADC_TRIG_OFFSET_EN
            // Pre-decrement so OFFSET exits after exactly offset edges.
            if (ofs_q != '0) begin
              ofs_d   = ofs_q - OFS_W'(1);
              state_d = ST_OFFSET;
            end else begin
              state_d = ST_CAPTURE;
            end
`else
            state_d = ST_CAPTURE;
`endif
          end
        end

`ifdef ADC_TRIG_OFFSET_EN
        ST_OFFSET: begin
          if (ofs_q == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            ofs_d = ofs_q - OFS_W'(1);
          end
        end
`endif

        ST_CAPTURE: begin
          // Compare before increment, so the counter can never wrap.
          if (count_q >= samples_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (bus.fifo_full_i) begin
            ovf_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wr_en_d = 1'b1;
            data_d  = bus.adc_data_i;
            count_d = count_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    armed_d = (state_d == ST_WAIT_INACT) || (state_d == ST_ARMED);
    cap_d   = (state_d == ST_OFFSET) || (state_d == ST_CAPTURE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      samples_q <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      armed_q   <= 1'b0;
      cap_q     <= 1'b0;
`ifdef ADC_TRIG_OFFSET_EN
      ofs_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      samples_q <= samples_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      armed_q   <= armed_d;
      cap_q     <= cap_d;
`ifdef ADC_TRIG_OFFSET_EN
      ofs_q     <= ofs_d;
`endif
    end
  end

  assign bus.fifo_wr_en_o = wr_en_q;
  assign bus.fifo_data_o  = data_q;
  assign bus.armed_o      = armed_q;
  assign bus.capturing_o  = cap_q;
  assign bus.done_o       = done_q;
  assign bus.overflow_o   = ovf_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_ctrl
// Self-checking bench for adc_capture_ctrl: directed capture scenarios plus
// a randomized run, all compared cycle by cycle against a behavioural model
// of the capture sequence. Honors ADC_TRIG_OFFSET_EN when defined.
// ---------------------------------------------------------------------------
module tb_adc_capture_ctrl;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OFS_W  = 32;

  // Model phases of a capture.
  localparam int PH_IDLE    = 0;
  localparam int PH_WAIT    = 1;
  localparam int PH_ARMED   = 2;
  localparam int PH_DELAY   = 3;
  localparam int PH_CAPTURE = 4;

  logic clk;
  logic reset;

  adc_capture_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W), .OFS_W(OFS_W)) bus ();

  adc_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .OFS_W(OFS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int obs_writes;
  int obs_done;

  // Behavioural model state
  int                m_phase;
  int                m_samples;
  int                m_offset;
  int                m_left;
  int                m_delay;
  logic              m_wr;
  logic              m_done;
  logic              m_ovf;
  logic [DATA_W-1:0] m_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_samples = 0;
    m_offset  = 0;
    m_left    = 0;
    m_delay   = 0;
    m_wr      = 1'b0;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
    m_data    = '0;
  endtask

  // One clock edge of the capture sequence, from the inputs seen at the edge.
  task automatic model_step();
    logic active;
    if (reset) begin
      model_reset();
      return;
    end
    active = (bus.trigger_i == bus.trigger_mode_i);
    m_wr   = 1'b0;
    m_done = 1'b0;
    if (bus.cmd_abort_i) begin
      m_phase = PH_IDLE;
    end else if (m_phase == PH_IDLE) begin
      if (bus.cmd_arm_i) begin
        m_samples = int'(bus.samples_i);
        m_offset  = int'(bus.offset_i);
        m_ovf     = 1'b0;
        m_phase   = bus.trigger_wait_i ? PH_WAIT : PH_ARMED;
      end
    end else if (m_phase == PH_WAIT) begin
      if (!active) m_phase = PH_ARMED;
    end else if (m_phase == PH_ARMED) begin
      if (active) begin
        m_left = m_samples;
`ifdef ADC_TRIG_OFFSET_EN
        m_delay = m_offset;
`else
        m_delay = 0;
`endif
        m_phase = (m_delay > 0) ? PH_DELAY : PH_CAPTURE;
      end
    end else if (m_phase == PH_DELAY) begin
      m_delay = m_delay - 1;
      if (m_delay == 0) m_phase = PH_CAPTURE;
    end else begin
      if (m_left == 0) begin
        m_done  = 1'b1;
        m_phase = PH_IDLE;
      end else if (bus.fifo_full_i) begin
        m_ovf   = 1'b1;
        m_done  = 1'b1;
        m_phase = PH_IDLE;
      end else begin
        m_wr   = 1'b1;
        m_data = bus.adc_data_i;
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic check_all();
    check_eq("wr_en",     32'(bus.fifo_wr_en_o), 32'(m_wr));
    check_eq("fifo_data", 32'(bus.fifo_data_o),  32'(m_data));
    check_eq("armed",     32'(bus.armed_o),      32'((m_phase == PH_WAIT) || (m_phase == PH_ARMED)));
    check_eq("capturing", 32'(bus.capturing_o),  32'((m_phase == PH_DELAY) || (m_phase == PH_CAPTURE)));
    check_eq("done",      32'(bus.done_o),       32'(m_done));
    check_eq("overflow",  32'(bus.overflow_o),   32'(m_ovf));
  endtask

  // Advance one clock, step the model, check, then present a ramp sample.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (bus.fifo_wr_en_o === 1'b1) obs_writes++;
    if (bus.done_o === 1'b1) obs_done++;
    check_all();
    cyc++;
    bus.adc_data_i = DATA_W'(cyc);
  endtask

  task automatic arm_pulse();
    bus.cmd_arm_i = 1'b1;
    tick();
    bus.cmd_arm_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int first;
    bit sent_arm;
    bit sent_abort;

    reset              = 1'b1;
    bus.cmd_arm_i      = 1'b0;
    bus.cmd_abort_i    = 1'b0;
    bus.trigger_i      = 1'b0;
    bus.trigger_mode_i = 1'b1;
    bus.trigger_wait_i = 1'b0;
    bus.samples_i      = '0;
    bus.offset_i       = '0;
    bus.adc_data_i     = '0;
    bus.fifo_full_i    = 1'b0;
    model_reset();
    obs_writes = 0;
    obs_done   = 0;

    // Reset state
    @(posedge clk);
    #1;
    check_all();
    tick();
    reset = 1'b0;
    tick();

    // Basic capture of 8 samples, trigger 5 cycles after arm
    bus.samples_i = CNT_W'(8);
    arm_pulse();
    repeat (4) tick();
    bus.trigger_i = 1'b1;
    obs_writes = 0; obs_done = 0; first = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (bus.fifo_wr_en_o === 1'b1 && first == 0) first = t;
    end
    bus.trigger_i = 1'b0;
    check_eq("s1_writes", 32'(obs_writes), 32'd8);
    check_eq("s1_first_wr", 32'(first), 32'd2);
    check_eq("s1_done_cnt", 32'(obs_done), 32'd1);
    check_eq("s1_armed_after", 32'(bus.armed_o), 32'd0);

    // Wait-for-inactive: trigger held active at arm
    bus.trigger_wait_i = 1'b1;
    bus.trigger_i      = 1'b1;
    bus.samples_i      = CNT_W'(3);
    obs_writes = 0;
    arm_pulse();
    repeat (5) tick();
    check_eq("s2_no_writes", 32'(obs_writes), 32'd0);
    check_eq("s2_armed", 32'(bus.armed_o), 32'd1);
    bus.trigger_i = 1'b0;
    repeat (2) tick();
    bus.trigger_i = 1'b1;
    first = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (bus.fifo_wr_en_o === 1'b1 && first == 0) first = t;
    end
    check_eq("s2_writes", 32'(obs_writes), 32'd3);
    check_eq("s2_first_wr", 32'(first), 32'd2);
    bus.trigger_wait_i = 1'b0;

    // FIFO full after 40 of 100 writes, then overflow cleared by next arm
    bus.samples_i = CNT_W'(100);
    bus.trigger_i = 1'b0;
    arm_pulse();
    bus.trigger_i = 1'b1;
    obs_writes = 0; obs_done = 0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (obs_writes == 40) bus.fifo_full_i = 1'b1;
    end
    bus.fifo_full_i = 1'b0;
    check_eq("s3_writes", 32'(obs_writes), 32'd40);
    check_eq("s3_done_cnt", 32'(obs_done), 32'd1);
    check_eq("s3_overflow", 32'(bus.overflow_o), 32'd1);
    bus.samples_i = CNT_W'(2);
    arm_pulse();
    check_eq("s3_ovf_clr", 32'(bus.overflow_o), 32'd0);
    repeat (6) tick();

    // Abort at write 3 of 10; arm during capture ignored
    bus.samples_i = CNT_W'(10);
    bus.trigger_i = 1'b0;
    arm_pulse();
    bus.trigger_i = 1'b1;
    obs_writes = 0; obs_done = 0; sent_arm = 0; sent_abort = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      bus.cmd_arm_i   = 1'b0;
      bus.cmd_abort_i = 1'b0;
      if (obs_writes == 1 && !sent_arm) begin
        bus.cmd_arm_i = 1'b1;
        bus.samples_i = CNT_W'(2);
        sent_arm = 1;
      end
      if (obs_writes == 3 && !sent_abort) begin
        bus.cmd_abort_i = 1'b1;
        sent_abort = 1;
      end
    end
    bus.cmd_arm_i   = 1'b0;
    bus.cmd_abort_i = 1'b0;
    check_eq("s4_writes", 32'(obs_writes), 32'd3);
    check_eq("s4_no_done", 32'(obs_done), 32'd0);
    check_eq("s4_idle", 32'(bus.capturing_o | bus.armed_o), 32'd0);

    // Zero-length capture
    bus.samples_i = CNT_W'(0);
    bus.trigger_i = 1'b0;
    arm_pulse();
    bus.trigger_i = 1'b1;
    obs_writes = 0; obs_done = 0;
    repeat (6) tick();
    check_eq("s5_writes", 32'(obs_writes), 32'd0);
    check_eq("s5_done_cnt", 32'(obs_done), 32'd1);

    // Reset mid-capture
    bus.samples_i = CNT_W'(10);
    bus.trigger_i = 1'b0;
    arm_pulse();
    bus.trigger_i = 1'b1;
    obs_writes = 0; obs_done = 0;
    for (int t = 0; t < 20 && obs_writes < 2; t++) tick();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_eq("s5_rst_done", 32'(obs_done), 32'd0);
    check_eq("s5_rst_wr", 32'(bus.fifo_wr_en_o), 32'd0);
    bus.trigger_i = 1'b0;

`ifdef ADC_TRIG_OFFSET_EN
    // Trigger offset of 20 clocks, 4 samples
    bus.samples_i = CNT_W'(4);
    bus.offset_i  = OFS_W'(20);
    arm_pulse();
    bus.trigger_i = 1'b1;
    obs_writes = 0; first = 0;
    for (int t = 1; t <= 32; t++) begin
      tick();
      if (bus.fifo_wr_en_o === 1'b1 && first == 0) first = t;
    end
    bus.trigger_i = 1'b0;
    check_eq("s6_first_wr", 32'(first), 32'd22);
    check_eq("s6_writes", 32'(obs_writes), 32'd4);
`endif

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      bus.cmd_arm_i   = ($urandom_range(0, 7) == 0);
      bus.cmd_abort_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) bus.trigger_i = ~bus.trigger_i;
      if ($urandom_range(0, 15) == 0) bus.trigger_mode_i = 1'($urandom_range(0, 1));
      bus.trigger_wait_i = 1'($urandom_range(0, 1));
      bus.samples_i      = CNT_W'($urandom_range(0, 12));
      bus.offset_i       = OFS_W'($urandom_range(0, 5));
      bus.fifo_full_i    = ($urandom_range(0, 15) == 0);
      bus.adc_data_i     = DATA_W'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
